// File: rtl/e_mdu_if.sv
// E-stage MDU port bundle: start/op/operands in, busy/stall/HI/LO/read value out.
// The slave side is the MDU; the master side is the pipeline (or a bench).
interface e_mdu_if;
  logic        md_start_E;
  logic [3:0]  MDUOp_E;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        busy_E;
  logic        md_stall_E;
  logic [31:0] E_MDout;
  logic [31:0] HI_E;
  logic [31:0] LO_E;

  modport master (
    output md_start_E, MDUOp_E, E_V1, E_V2,
    input  busy_E, md_stall_E, E_MDout, HI_E, LO_E
  );

  modport slave (
    input  md_start_E, MDUOp_E, E_V1, E_V2,
    output busy_E, md_stall_E, E_MDout, HI_E, LO_E
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO update MULT_CYCLES/DIV_CYCLES after accept; starts while busy are
// dropped, md_stall_E tells the hazard unit to hold MDU ops. Define MDU_MADD_EN to enable madd/maddu.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave mdu
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          busy;
  logic          is_start_op;
  logic          is_div_op;
  logic          accept;

  logic [63:0]   a_sx, b_sx, a_zx, b_zx;
  logic [63:0]   prod_s, prod_u;
  logic          b_zero, div_ovf;
  logic [31:0]   divisor_s, divisor_u;
  logic [31:0]   quot_s, rem_s, quot_u, rem_u;
  logic [31:0]   res_hi, res_lo;

  assign busy = (cnt_q != '0);

  always_comb begin
    is_start_op = 1'b0;
    is_div_op   = 1'b0;
    case (mdu.MDUOp_E)
      OP_MULT, OP_MULTU: is_start_op = 1'b1;
      OP_DIV, OP_DIVU: begin
        is_start_op = 1'b1;
        is_div_op   = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: is_start_op = 1'b1;
`endif
      default: is_start_op = 1'b0;
    endcase
  end

  assign accept = mdu.md_start_E && !busy && is_start_op;

  // Products are formed at full 64-bit width from explicitly extended operands.
  assign a_sx   = {{32{mdu.E_V1[31]}}, mdu.E_V1};
  assign b_sx   = {{32{mdu.E_V2[31]}}, mdu.E_V2};
  assign a_zx   = {32'd0, mdu.E_V1};
  assign b_zx   = {32'd0, mdu.E_V2};
  assign prod_s = $signed(a_sx) * $signed(b_sx);
  assign prod_u = a_zx * b_zx;

  // Divisor of 1 in the zero and INT_MIN/-1 cases keeps the divider defined;
  // INT_MIN/1 already yields the required quotient 0x80000000, remainder 0.
  assign b_zero    = (mdu.E_V2 == 32'd0);
  assign div_ovf   = (mdu.E_V1 == 32'h8000_0000) && (mdu.E_V2 == 32'hFFFF_FFFF);
  assign divisor_s = (b_zero || div_ovf) ? 32'd1 : mdu.E_V2;
  assign divisor_u = b_zero ? 32'd1 : mdu.E_V2;
  assign quot_s    = $signed(mdu.E_V1) / $signed(divisor_s);
  assign rem_s     = $signed(mdu.E_V1) % $signed(divisor_s);
  assign quot_u    = mdu.E_V1 / divisor_u;
  assign rem_u     = mdu.E_V1 % divisor_u;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (mdu.MDUOp_E)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (!b_zero) begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (!b_zero) begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
`endif
      default: begin
        res_hi = hi_q;
        res_lo = lo_q;
      end
    endcase
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    cnt_d    = cnt_q;
    if (accept) begin
      tmp_hi_d = res_hi;
      tmp_lo_d = res_lo;
      cnt_d    = is_div_op ? DIV_LD : MULT_LD;
    end else if (cnt_q == CNT_ONE) begin
      hi_d  = tmp_hi_q;
      lo_d  = tmp_lo_q;
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q - CNT_ONE;
    end else if (!mdu.md_start_E) begin
      if (mdu.MDUOp_E == OP_MTHI) hi_d = mdu.E_V1;
      if (mdu.MDUOp_E == OP_MTLO) lo_d = mdu.E_V1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    case (mdu.MDUOp_E)
      OP_MFHI: mdu.E_MDout = hi_q;
      OP_MFLO: mdu.E_MDout = lo_q;
      default: mdu.E_MDout = 32'd0;
    endcase
  end

  assign mdu.busy_E     = busy;
  assign mdu.md_stall_E = busy | mdu.md_start_E;
  assign mdu.HI_E       = hi_q;
  assign mdu.LO_E       = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: fixed vector table, hand sequences for reset/interference, and
// randomized ops checked against an arithmetic reference of HI/LO.
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   applied;
  int   errors;
  logic [31:0] m_hi, m_lo;

  e_mdu_if ifc ();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          exp_n;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the architectural effect of one op on {HI,LO} and its busy length.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] nhi, output logic [31:0] nlo, output int n);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nhi = hi;
    nlo = lo;
    n = 0;
    case (op)
      4'd1: begin p = sa * sb; {nhi, nlo} = p; n = MC; end
      4'd2: begin p = ua * ub; {nhi, nlo} = p; n = MC; end
      4'd3: begin
        n = DC;
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          nlo = q[31:0]; nhi = r[31:0];
        end
      end
      4'd4: begin
        n = DC;
        if (b != 0) begin
          uq = ua / ub; ur = ua % ub;
          nlo = uq[31:0]; nhi = ur[31:0];
        end
      end
`ifdef MDU_MADD_EN
      4'd9:  begin p = {hi, lo} + sa * sb; {nhi, nlo} = p; n = MC; end
      4'd10: begin p = {hi, lo} + ua * ub; {nhi, nlo} = p; n = MC; end
`endif
      default: n = 0;
    endcase
  endfunction

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    ifc.md_start_E = 1'b0;
    ifc.MDUOp_E    = op;
    ifc.E_V1       = v;
    @(negedge clk);
    ifc.MDUOp_E    = 4'd0;
  endtask

  // intf: 0 none, 1 second start in busy cycle 2, 2 mthi 0xABCD in busy cycle 2
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int intf);
    int cnt;
    bit stall_ok;
    @(negedge clk);
    ifc.md_start_E = 1'b1;
    ifc.MDUOp_E    = op;
    ifc.E_V1       = a;
    ifc.E_V2       = b;
    #1 check({name, " stall@start"}, {31'd0, ifc.md_stall_E}, 32'd1);
    @(negedge clk);
    ifc.md_start_E = 1'b0;
    ifc.MDUOp_E    = 4'd0;
    cnt = 0;
    stall_ok = 1'b1;
    while (ifc.busy_E === 1'b1 && cnt < 200) begin
      cnt++;
      if (ifc.md_stall_E !== 1'b1) stall_ok = 1'b0;
      if (cnt == 2 && intf == 1) begin
        ifc.md_start_E = 1'b1;
        ifc.MDUOp_E    = 4'd4;
        ifc.E_V1       = 32'd100;
        ifc.E_V2       = 32'd7;
      end else if (cnt == 2 && intf == 2) begin
        ifc.MDUOp_E = 4'd7;
        ifc.E_V1    = 32'h0000_ABCD;
      end else begin
        ifc.md_start_E = 1'b0;
        ifc.MDUOp_E    = 4'd0;
      end
      @(negedge clk);
    end
    ifc.md_start_E = 1'b0;
    ifc.MDUOp_E    = 4'd0;
    check({name, " busy_cycles"}, 32'(cnt), 32'(exp_n));
    check({name, " stall_in_busy"}, {31'd0, stall_ok}, 32'd1);
    check({name, " HI"}, ifc.HI_E, exp_hi);
    check({name, " LO"}, ifc.LO_E, exp_lo);
  endtask

  task automatic check_reads(input string name);
    @(negedge clk);
    ifc.MDUOp_E = 4'd5;
    #1 check({name, " mfhi"}, ifc.E_MDout, m_hi);
    ifc.MDUOp_E = 4'd6;
    #1 check({name, " mflo"}, ifc.E_MDout, m_lo);
    ifc.MDUOp_E = 4'd0;
  endtask

  initial begin
    applied = 0;
    errors  = 0;
    reset   = 1'b0;
    ifc.md_start_E = 1'b0;
    ifc.MDUOp_E    = 4'd0;
    ifc.E_V1       = 32'd0;
    ifc.E_V2       = 32'd0;

    vt[0] = '{"mult",      4'd1,  32'hFFFF_FFFF, 32'd2,         32'd0,  32'd0,         MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[1] = '{"multu",     4'd2,  32'hFFFF_FFFF, 32'd2,         32'd0,  32'd0,         MC, 32'h0000_0001, 32'hFFFF_FFFE};
    vt[2] = '{"div-7/2",   4'd3,  32'hFFFF_FFF9, 32'd2,         32'd0,  32'd0,         DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{"divu7/0",   4'd4,  32'd7,         32'd0,         32'h11, 32'h22,        DC, 32'h11,        32'h22};
    vt[4] = '{"div_ovf",   4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'd5,  32'd6,         DC, 32'd0,         32'h8000_0000};
    vt[5] = '{"div7/-2",   4'd3,  32'd7,         32'hFFFF_FFFE, 32'd0,  32'd0,         DC, 32'd1,         32'hFFFF_FFFD};
    vt[6] = '{"div0/0",    4'd3,  32'd0,         32'd0,         32'h77, 32'h88,        DC, 32'h77,        32'h88};
    vt[7] = '{"op12",      4'd12, 32'd3,         32'd4,         32'd5,  32'd6,         0,  32'd5,         32'd6};
`ifdef MDU_MADD_EN
    vt[8] = '{"madd",      4'd9,  32'd1,         32'd1,         32'd0,  32'hFFFF_FFFF, MC, 32'd1,         32'd0};
    vt[9] = '{"maddu",     4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'd1,         MC, 32'hFFFF_FFFE, 32'd2};
`else
    vt[8] = '{"madd_off",  4'd9,  32'd1,         32'd1,         32'd0,  32'hFFFF_FFFF, 0,  32'd0,         32'hFFFF_FFFF};
    vt[9] = '{"maddu_off", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'd1,         0,  32'd0,         32'd1};
`endif

    #1;
    check("rst busy", {31'd0, ifc.busy_E}, 32'd0);
    check("rst stall", {31'd0, ifc.md_stall_E}, 32'd0);
    check("rst HI", ifc.HI_E, 32'd0);
    check("rst LO", ifc.LO_E, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    mt(4'd7, 32'h1234);
    mt(4'd8, 32'h5678);
    check("mthi", ifc.HI_E, 32'h1234);
    check("mtlo", ifc.LO_E, 32'h5678);
    m_hi = 32'h1234;
    m_lo = 32'h5678;
    check_reads("mt");

    foreach (vt[i]) begin
      mt(4'd7, vt[i].pre_hi);
      mt(4'd8, vt[i].pre_lo);
      run_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].exp_n, vt[i].exp_hi, vt[i].exp_lo, 0);
    end

    run_op("restart_ignored", 4'd1, 32'd6, 32'd7, MC, 32'd0, 32'd42, 1);
    run_op("mthi_in_busy", 4'd1, 32'd3, 32'd4, MC, 32'd0, 32'd12, 2);

    // Reset mid-divide with the counter at 4.
    mt(4'd7, 32'h33);
    mt(4'd8, 32'h44);
    @(negedge clk);
    ifc.md_start_E = 1'b1;
    ifc.MDUOp_E    = 4'd3;
    ifc.E_V1       = 32'd100;
    ifc.E_V2       = 32'd3;
    @(negedge clk);
    ifc.md_start_E = 1'b0;
    ifc.MDUOp_E    = 4'd0;
    repeat (6) @(negedge clk);
    check("pre-rst busy", {31'd0, ifc.busy_E}, 32'd1);
    reset = 1'b0;
    #1;
    check("async busy", {31'd0, ifc.busy_E}, 32'd0);
    check("async HI", ifc.HI_E, 32'd0);
    check("async LO", ifc.LO_E, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      bit quiet;
      quiet = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (ifc.busy_E !== 1'b0 || ifc.HI_E !== 32'd0 || ifc.LO_E !== 32'd0) quiet = 1'b0;
      end
      check("post-rst idle", {31'd0, quiet}, 32'd1);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;

    for (int it = 0; it < 40; it++) begin
      logic [3:0]  op;
      logic [31:0] a, b, nhi, nlo;
      int          n, pick;
      logic [3:0]  ops [10];
      logic [31:0] spec_v [5];
      ops    = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd7, 4'd8, 4'd12, 4'd0};
      spec_v = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF};
      pick = $urandom_range(0, 9);
      op = ops[pick];
      a = ($urandom_range(0, 3) == 0) ? spec_v[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? spec_v[$urandom_range(0, 4)] : $urandom;
      if (op == 4'd7 || op == 4'd8) begin
        mt(op, a);
        if (op == 4'd7) m_hi = a; else m_lo = a;
        check("rnd mt HI", ifc.HI_E, m_hi);
        check("rnd mt LO", ifc.LO_E, m_lo);
      end else begin
        model(op, a, b, m_hi, m_lo, nhi, nlo, n);
        run_op($sformatf("rnd%0d op%0d", it, op), op, a, b, n, nhi, nlo, 0);
        m_hi = nhi;
        m_lo = nlo;
      end
      if (it % 5 == 0) check_reads($sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the P6 pipelined MIPS core.
- Consumes forwarded E-stage operands and MDU opcode.
- Produces the HI/LO read value that joins E_AO selection ahead of regM, plus busy/stall status for the hazard unit.
- Models fixed multi-cycle mult/div latency with an internal countdown.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (and madd/maddu when enabled); must be >=1
- DIV_CYCLES, 10, busy duration for div/divu; must be >=1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
- md_start_E  input  1  one-cycle start for a mult/div-class op in E
- MDUOp_E  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu; others = none
- E_V1  input  32  forwarded rs value
- E_V2  input  32  forwarded rt value
- busy_E  output  1  operation in progress
- md_stall_E  output  1  combinational: busy_E | md_start_E, for hazard unit to stall any MDU op in D
- E_MDout  output  32  combinational: HI if MDUOp_E==5, LO if 6, else 0
- HI_E  output  32  architectural HI
- LO_E  output  32  architectural LO

Behaviour:
- Reset (reset==0, async): HI, LO, tmp_hi, tmp_lo = 0; counter = 0; busy_E = 0. An in-flight op is discarded.
- Start accepted at posedge when md_start_E==1, busy_E==0, and op in {1,2,3,4,9,10}.
- On accept, tmp_hi/tmp_lo are computed from E_V1/E_V2 at that edge:
  - mult: signed 64-bit product; multu: unsigned; {tmp_hi,tmp_lo} = product.
  - div: tmp_lo = signed quotient (truncate toward zero), tmp_hi = signed remainder (sign of dividend).
  - divu: unsigned quotient/remainder.
  - div/divu with E_V2==0: tmp_hi/tmp_lo = current HI/LO, so HI/LO stay unchanged at completion. Busy timing is still DIV_CYCLES.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Counter load on accept: MULT_CYCLES or DIV_CYCLES. busy_E = 1 from the cycle after the accept edge.
- Each edge with counter>1: counter decrements.
- Edge with counter==1: HI<=tmp_hi, LO<=tmp_lo, counter<=0, busy_E<=0.
- busy_E is high for exactly N cycles; new HI/LO are visible in the first cycle busy_E is low.
- md_start_E while busy_E==1: ignored; no state change.
- md_start_E with a non-start op: ignored.
- mthi (7) / mtlo (8):
  - Take effect at the posedge when busy_E==0 and md_start_E==0 in the same cycle (independent of md_start_E otherwise): HI<=E_V1 or LO<=E_V1.
  - Ignored while busy_E==1 (hazard unit guarantees this cannot happen legally).
- mfhi/mflo read HI/LO directly. No bypass of pending tmp values; stall guarantees ordering.
- Undefined op codes (11-15): behave as none.
- All arithmetic uses 64-bit intermediates. No exceptions raised.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 9/10 valid start ops.
  - madd: {tmp_hi,tmp_lo} = {HI,LO} + signed product, modulo 2^64.
  - maddu: same with unsigned product.
  - Latency MULT_CYCLES.
- Undefined: codes 9/10 treated as none (no start, busy_E stays 0, md_stall_E still reflects md_start_E).

Test Plan:
- Reset low mid-div (counter=4), then release -> HI=LO=0, busy_E=0 immediately while reset low, counter 0 after release.
- mult 0xFFFFFFFF x 0x00000002 -> busy_E high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div -7 / 2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with prior HI=0x11, LO=0x22 -> unchanged after 10 cycles.
- mthi 0x1234, mtlo 0x5678 when idle -> next cycle HI=0x1234, LO=0x5678. With MDUOp_E=5, E_MDout=0x1234; with 6, E_MDout=0x5678. mthi 0xABCD issued during busy -> HI not written.
- Second md_start_E at cycle 2 of a mult -> ignored, busy_E drops after original 5 cycles. md_stall_E==1 in the start cycle and all busy cycles.
- MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF, madd 1x1 -> HI=1, LO=0 after 5 cycles. Macro undefined -> busy_E stays 0, HI/LO unchanged.
